// File: rtl/pe_input_skew_feeder.sv
// Input skew feeder for the top row of the systolic PE array.
// Lane j is delayed by j cycles, and done pulses when the frame drains.
module pe_input_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_enable,
    output logic               busy,
    output logic               done,
    output logic [31:0]        vec_count
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] vec_count_q, vec_count_d;
    logic        accept;

    assign in_ready  = (state_q != DRAIN);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign vec_count = vec_count_q;

    // Frame tracking: next state, drain countdown, done pulse, vector count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        vec_count_d = vec_count_q;
        if (accept && (vec_count_q != '1)) begin
            vec_count_d = vec_count_q + 32'd1;
        end
        unique case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (!in_last) begin
                        state_d = STREAM;
                    end else if (N == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; flush clears them like reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            vec_count_q <= vec_count_d;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [WIDTH-1:0] d_q [0:j];
        logic [j:0]       en_q;

        // Lane shift chain of j+1 stages; idle cycles enter as zero bubbles.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= j; k++) begin
                    d_q[k] <= '0;
                end
                en_q <= '0;
            end else if (flush) begin
                for (int k = 0; k <= j; k++) begin
                    d_q[k] <= '0;
                end
                en_q <= '0;
            end else begin
                d_q[0]  <= accept ? in_data[j*WIDTH +: WIDTH] : '0;
                en_q[0] <= accept;
                for (int k = 1; k <= j; k++) begin
                    d_q[k]  <= d_q[k-1];
                    en_q[k] <= en_q[k-1];
                end
            end
        end

        assign out_data[j*WIDTH +: WIDTH] = d_q[j];
        assign out_enable[j]              = en_q[j];
    end

endmodule

// File: tb/tb_pe_input_skew_feeder.sv
// Bench for pe_input_skew_feeder: directed frames checked against
// per-lane expectation queues and a small handshake/frame model.
module tb_pe_input_skew_feeder;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_data;
    logic             in_last;
    logic [N*W-1:0]   out_data;
    logic [N-1:0]     out_enable;
    logic             busy;
    logic             done;
    logic [31:0]      vec_count;

    always #5 clk = ~clk;

    pe_input_skew_feeder #(.WIDTH(W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_enable (out_enable),
        .busy       (busy),
        .done       (done),
        .vec_count  (vec_count)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
    } ent_t;

    ent_t        exq [N][$];
    int          cyc;
    int          passed;
    int          total;
    int          fails;
    logic [31:0] m_cnt;
    bit          m_stream;
    int          m_ready_from;
    int          m_done_at;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < N; j++) exq[j].delete();
        m_cnt        = '0;
        m_stream     = 1'b0;
        m_ready_from = 0;
        m_done_at    = -1;
    endtask

    task automatic check_cycle();
        logic [N-1:0]   een;
        logic [N*W-1:0] edat;
        bit             rdy;
        een  = '0;
        edat = '0;
        for (int j = 0; j < N; j++) begin
            if (exq[j].size() > 0 && exq[j][0].cyc == cyc) begin
                een[j]          = 1'b1;
                edat[j*W +: W]  = exq[j][0].val;
                void'(exq[j].pop_front());
            end
        end
        rdy = (cyc >= m_ready_from);
        chk("enable", out_enable, een);
        chk("data", out_data, edat);
        chk("ready", in_ready, rdy);
        chk("busy", busy, m_stream || !rdy);
        chk("done", done, cyc == m_done_at);
        chk("vec_count", vec_count, m_cnt);
    endtask

    task automatic tick();
        int e;
        e = cyc + 1;
        if (flush) begin
            model_clear();
        end else if (in_valid && cyc >= m_ready_from) begin
            for (int j = 0; j < N; j++) begin
                exq[j].push_back('{e + j, in_data[j*W +: W]});
            end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (in_last) begin
                m_stream     = 1'b0;
                m_ready_from = e + N - 1;
                m_done_at    = e + N - 1;
            end else begin
                m_stream = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        check_cycle();
    endtask

    task automatic drive(input bit v, input bit l,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3);
        in_valid = v;
        in_last  = l;
        in_data  = {d3, d2, d1, d0};
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] c0;
        passed = 0;
        total  = 0;
        fails  = 0;
        cyc    = 0;
        model_clear();
        rst    = 1'b0;
        flush  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        #3;
        chk("rst_data", out_data, 0);
        chk("rst_enable", out_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_cycle();

        // single-vector frame
        drive(1, 1, 1, 2, 3, 4);
        tick();
        idle(6);

        // three back-to-back vectors
        drive(1, 0, 16'h11, 16'h12, 16'h13, 16'h14);
        tick();
        drive(1, 0, 16'h21, 16'h22, 16'h23, 16'h24);
        tick();
        drive(1, 1, 16'h31, 16'h32, 16'h33, 16'h34);
        tick();
        chk("b2b_en", out_enable, 4'b0111);
        idle(1);
        chk("b2b_en2", out_enable, 4'b1110);
        idle(6);

        // bubble inside a frame
        drive(1, 0, 16'hA0, 16'hA1, 16'hA2, 16'hA3);
        tick();
        idle(1);
        drive(1, 1, 16'hB0, 16'hB1, 16'hB2, 16'hB3);
        tick();
        idle(6);

        // signed extremes
        drive(1, 1, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000);
        tick();
        idle(6);

        // stall: hold a vector through drain
        drive(1, 1, 16'h0C1, 16'h0C2, 16'h0C3, 16'h0C4);
        tick();
        c0 = vec_count;
        drive(1, 1, 16'h0D1, 16'h0D2, 16'h0D3, 16'h0D4);
        for (int k = 0; k < 10 && !in_ready; k++) tick();
        chk("stall_held", vec_count, c0);
        tick();
        chk("stall_accept", vec_count, c0 + 32'd1);
        idle(6);

        // async reset mid-frame
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 16'h51 + 16'(i), 16'h61 + 16'(i),
                  16'h71 + 16'(i), 16'h81 + 16'(i));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("arst_data", out_data, 0);
        chk("arst_enable", out_enable, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_vec", vec_count, 0);
        chk("arst_ready", in_ready, 1);
        #2;
        rst = 1'b1;
        idle(6);

        // flush mid-frame, handshake in the same cycle discarded
        drive(1, 0, 16'h91, 16'h92, 16'h93, 16'h94);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_vec", vec_count, 0);
        chk("flush_data", out_data, 0);
        idle(6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
